// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM states, backing-store
// address mapping for the instruction space and the abort fill word.
package mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRD,
      ST_DWR,
      ST_ILO,
      ST_IHI,
      ST_HOLD,
      ST_WDONE,
      ST_RELEASE
   } state_e;

   // The instruction-space select bit sits this many places below the top
   // of the backing word address (i.e. it is the MSB).
   localparam int INSTR_SEL_FROM_TOP = 1;

   // Data returned for a transaction that was abandoned by the timeout.
   localparam logic [15:0] ABORT_FILL = 16'hFFFF;

   // Backing word address for a request. Data space maps 1:1; instruction
   // space sets the select bit and uses two words per 32-bit instruction.
   function automatic logic [31:0] map_addr(input logic [15:0] addr,
                                            input logic        instr,
                                            input logic        hi,
                                            input int          ba_w);
      logic [31:0] a;
      if (instr) begin
         a = (32'd1 << (ba_w - INSTR_SEL_FROM_TOP)) | {15'd0, addr, hi};
      end else begin
         a = {16'd0, addr};
      end
      return a;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side memory bus plus backing-store port of the memory responder.
// The responder uses the slave modport; the core/backing-store side uses master.
interface mem_responder_if #(
   parameter int BA_W = 18
);
   // core request side
   logic [15:0]     addr_bus;
   logic [15:0]     data_in;
   logic            ram_read;
   logic            ram_write;
   logic            ram_instr_access;
   logic            ram_read_done;
   // core response side
   logic [15:0]     mem_bus;
   logic [31:0]     sdram_instr;
   logic            mem_busy;
   logic            mem_ready;
   logic            ram_cack;
   // backing-store port
   logic            b_req;
   logic            b_we;
   logic [BA_W-1:0] b_addr;
   logic [15:0]     b_wdata;
   logic [15:0]     b_rdata;
   logic            b_ack;
   logic            err;

   modport slave (
      input  addr_bus, data_in, ram_read, ram_write, ram_instr_access,
             ram_read_done, b_rdata, b_ack,
      output mem_bus, sdram_instr, mem_busy, mem_ready, ram_cack,
             b_req, b_we, b_addr, b_wdata, err
   );

   modport master (
      output addr_bus, data_in, ram_read, ram_write, ram_instr_access,
             ram_read_done, b_rdata, b_ack,
      input  mem_bus, sdram_instr, mem_busy, mem_ready, ram_cack,
             b_req, b_we, b_addr, b_wdata, err
   );
endinterface

// File: rtl/mem_resp_bport.sv
// Backing-store request port: holds b_req/b_addr/b_we/b_wdata from issue
// until b_ack, reports done/abort to the responder FSM.
// Optional macro MEM_TIMEOUT_EN adds a no-ack timeout with sticky err.
module mem_resp_bport #(
   parameter int BA_W = 18
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 255
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            we_i,
   input  logic [BA_W-1:0] addr_i,
   input  logic [15:0]     wdata_i,
   input  logic            b_ack_i,
   output logic            b_req_o,
   output logic            b_we_o,
   output logic [BA_W-1:0] b_addr_o,
   output logic [15:0]     b_wdata_o,
   output logic            done_o,
   output logic            abort_o,
   output logic            err_o
);

   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [BA_W-1:0] addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            abort;

   // An ack only counts while a request is outstanding.
   assign done_o = req_q & b_ack_i;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Give up in the TIMEOUT-th outstanding cycle if no ack arrived in it.
   assign abort = req_q & ~b_ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));

   // Cycle counter: cleared on every issue, counts while b_req is held.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (req_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (abort) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign abort = 1'b0;
   assign err_o = 1'b0;
`endif

   assign abort_o = abort;

   // Request hold: load on start, release the cycle after ack or abort.
   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (start_i) begin
         req_d   = 1'b1;
         we_d    = we_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
      end else if (done_o || abort) begin
         req_d = 1'b0;
         we_d  = 1'b0;
      end
   end

   // Request registers; reset drops b_req at once, abandoning any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign b_req_o   = req_q;
   assign b_we_o    = we_q;
   assign b_addr_o  = addr_q;
   assign b_wdata_o = wdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serves core data reads, data writes and 32-bit
// instruction fetches by issuing one or two word transfers on the
// backing-store port. Optional macro MEM_TIMEOUT_EN enables the no-ack
// timeout (abandoned transfers complete with 16'hFFFF and set err).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int BA_W = 18
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 255
`endif
) (
   input logic           clk,
   input logic           rst,
   mem_responder_if.slave bus
);

   state_e          state_q, state_d;
   logic [15:0]     addr_q;
   logic            cack_q;
   logic [15:0]     mem_bus_q;
   logic [31:0]     sdram_instr_q;

   logic            bp_start;
   logic            bp_we;
   logic [BA_W-1:0] bp_addr;
   logic [15:0]     bp_wdata;
   logic            bp_req;
   logic            bp_done;
   logic            bp_abort;
   logic            bp_err;
   logic            fin;
   logic [15:0]     rdata_eff;
   logic            capture;

   // A timed-out transfer finishes like an acked one carrying the fill word.
   assign fin       = bp_done | bp_abort;
   assign rdata_eff = bp_abort ? ABORT_FILL : bus.b_rdata;
   assign capture   = (state_q == ST_IDLE) && bp_start;

   mem_resp_bport #(
      .BA_W    (BA_W)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT (TIMEOUT)
`endif
   ) u_bport (
      .clk       (clk),
      .rst       (rst),
      .start_i   (bp_start),
      .we_i      (bp_we),
      .addr_i    (bp_addr),
      .wdata_i   (bp_wdata),
      .b_ack_i   (bus.b_ack),
      .b_req_o   (bp_req),
      .b_we_o    (bus.b_we),
      .b_addr_o  (bus.b_addr),
      .b_wdata_o (bus.b_wdata),
      .done_o    (bp_done),
      .abort_o   (bp_abort),
      .err_o     (bp_err)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and backing-port issue; requests are only sampled in IDLE.
   always_comb begin
      state_d  = state_q;
      bp_start = 1'b0;
      bp_we    = 1'b0;
      bp_addr  = '0;
      bp_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.ram_write) begin
               // write wins over a simultaneous read
               bp_start = 1'b1;
               bp_we    = 1'b1;
               bp_addr  = BA_W'(map_addr(bus.addr_bus, 1'b0, 1'b0, BA_W));
               bp_wdata = bus.data_in;
               state_d  = ST_DWR;
            end else if (bus.ram_read) begin
               bp_start = 1'b1;
               if (bus.ram_instr_access) begin
                  bp_addr = BA_W'(map_addr(bus.addr_bus, 1'b1, 1'b0, BA_W));
                  state_d = ST_ILO;
               end else begin
                  bp_addr = BA_W'(map_addr(bus.addr_bus, 1'b0, 1'b0, BA_W));
                  state_d = ST_DRD;
               end
            end
         end
         ST_DRD: begin
            if (fin) state_d = ST_HOLD;
         end
         ST_DWR: begin
            if (fin) state_d = ST_WDONE;
         end
         ST_ILO: begin
            if (fin) state_d = ST_IHI;
         end
         ST_IHI: begin
            // b_req is low only on the entry cycle: issue the high half then
            if (!bp_req) begin
               bp_start = 1'b1;
               bp_addr  = BA_W'(map_addr(addr_q, 1'b1, 1'b1, BA_W));
            end else if (fin) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.ram_read_done) state_d = ST_RELEASE;
         end
         ST_WDONE: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            // wait for the core to drop its request level so it is not re-served
            if (!bus.ram_read && !bus.ram_write) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command capture, ack pulse and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         cack_q        <= 1'b0;
         mem_bus_q     <= '0;
         sdram_instr_q <= '0;
      end else begin
         cack_q <= capture;
         if (capture) begin
            addr_q <= bus.addr_bus;
         end
         if (state_q == ST_DRD && fin) begin
            mem_bus_q <= rdata_eff;
         end
         if (state_q == ST_ILO && fin) begin
            sdram_instr_q[15:0] <= rdata_eff;
         end
         if (state_q == ST_IHI && fin) begin
            sdram_instr_q[31:16] <= rdata_eff;
         end
      end
   end

   assign bus.mem_bus     = mem_bus_q;
   assign bus.sdram_instr = sdram_instr_q;
   assign bus.ram_cack    = cack_q;
   assign bus.b_req       = bp_req;
   assign bus.err         = bp_err;
   assign bus.mem_busy    = state_q inside {ST_DRD, ST_DWR, ST_ILO, ST_IHI};
   assign bus.mem_ready   = state_q inside {ST_HOLD, ST_WDONE};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a transaction-level model of the
// expected backing-store traffic and read results.
module tb_mem_responder;

   logic clk;
   logic rst;

   mem_responder_if #(.BA_W(18)) bus ();

`ifdef MEM_TIMEOUT_EN
   mem_responder #(.BA_W(18), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   mem_responder #(.BA_W(18)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] addr;
      logic        we;
      logic [15:0] wdata;
   } btx_t;

   btx_t        exp_q[$];
   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   int          cack_cnt = 0;
   int          mode     = 0;     // 0: no read result expected, 1: data, 2: instr
   logic [15:0] exp_bus  = '0;
   logic [31:0] exp_instr = '0;
   logic        req_prev = 1'b0;
   logic [17:0] held_addr = '0;
   logic        held_we = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Expected backing addresses from the mapping rules.
   function automatic logic [17:0] daddr(input int a);
      return 18'(a);
   endfunction
   function automatic logic [17:0] iaddr(input int a, input int hi);
      return 18'(32'h20000 + 2 * a + hi);
   endfunction

   task automatic expect_tx(input logic [17:0] a, input logic w, input logic [15:0] d);
      btx_t t;
      t.addr = a; t.we = w; t.wdata = d;
      exp_q.push_back(t);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Pulse b_ack after d further cycles; returns one cycle after the ack cycle.
   task automatic ack_after(input int d, input logic [15:0] data);
      repeat (d) cyc();
      bus.b_ack = 1'b1;
      bus.b_rdata = data;
      cyc();
      bus.b_ack = 1'b0;
      bus.b_rdata = '0;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         req_prev <= 1'b0;
      end else begin
         chk("busy_ready_excl", 64'(bus.mem_busy & bus.mem_ready), 64'd0);
         if (bus.ram_cack) cack_cnt <= cack_cnt + 1;
         if (bus.b_req && !req_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_breq", 64'd1, 64'd0);
            end else begin
               btx_t t;
               t = exp_q.pop_front();
               chk("model_b_addr", 64'(bus.b_addr), 64'(t.addr));
               chk("model_b_we", 64'(bus.b_we), 64'(t.we));
               if (t.we) chk("model_b_wdata", 64'(bus.b_wdata), 64'(t.wdata));
            end
            held_addr <= bus.b_addr;
            held_we   <= bus.b_we;
         end else if (bus.b_req) begin
            chk("b_addr_stable", 64'(bus.b_addr), 64'(held_addr));
            chk("b_we_stable", 64'(bus.b_we), 64'(held_we));
         end
         if (bus.mem_ready && mode == 1) chk("model_mem_bus", 64'(bus.mem_bus), 64'(exp_bus));
         if (bus.mem_ready && mode == 2) chk("model_instr", 64'(bus.sdram_instr), 64'(exp_instr));
         req_prev <= bus.b_req;
      end
   end

   initial begin
      bus.addr_bus = '0; bus.data_in = '0; bus.ram_read = 0; bus.ram_write = 0;
      bus.ram_instr_access = 0; bus.ram_read_done = 0; bus.b_rdata = '0; bus.b_ack = 0;
      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_mem_bus", 64'(bus.mem_bus), 64'd0);
      chk("rst_instr", 64'(bus.sdram_instr), 64'd0);
      chk("rst_flags", 64'({bus.mem_busy, bus.mem_ready, bus.ram_cack, bus.b_req, bus.b_we, bus.err}), 64'd0);
      chk("rst_b_addr", 64'(bus.b_addr), 64'd0);
      chk("rst_b_wdata", 64'(bus.b_wdata), 64'd0);
      rst = 1'b0;
      cyc();

      // data read 0x1234, ack 3 cycles after b_req with 0xBEEF
      mode = 1; exp_bus = 16'hBEEF;
      expect_tx(daddr(16'h1234), 1'b0, 16'h0);
      bus.addr_bus = 16'h1234; bus.ram_read = 1;
      cyc();
      chk("rd_cack", 64'(bus.ram_cack), 64'd1);
      chk("rd_busy", 64'(bus.mem_busy), 64'd1);
      chk("rd_breq", 64'(bus.b_req), 64'd1);
      chk("rd_baddr", 64'(bus.b_addr), 64'h01234);
      cyc();
      chk("rd_cack_once", 64'(bus.ram_cack), 64'd0);
      ack_after(2, 16'hBEEF);
      chk("rd_ready", 64'({bus.mem_ready, bus.mem_busy, bus.b_req}), 64'b100);
      chk("rd_data", 64'(bus.mem_bus), 64'hBEEF);
      repeat (3) cyc();
      chk("rd_hold_ready", 64'(bus.mem_ready), 64'd1);
      chk("rd_hold_data", 64'(bus.mem_bus), 64'hBEEF);
      bus.ram_read_done = 1;
      cyc();
      bus.ram_read_done = 0;
      chk("rd_ready_drop", 64'(bus.mem_ready), 64'd0);
      repeat (3) cyc();
      chk("rd_no_reserve", 64'({bus.b_req, bus.mem_busy, bus.ram_cack}), 64'd0);
      bus.ram_read = 0;
      repeat (2) cyc();
      chk("rd_cack_count", 64'(cack_cnt), 64'd1);

      // write 0xA5A5 to 0x0010
      mode = 0;
      expect_tx(daddr(16'h0010), 1'b1, 16'hA5A5);
      bus.addr_bus = 16'h0010; bus.data_in = 16'hA5A5; bus.ram_write = 1;
      cyc();
      chk("wr_bwe", 64'(bus.b_we), 64'd1);
      chk("wr_bwdata", 64'(bus.b_wdata), 64'hA5A5);
      chk("wr_baddr", 64'(bus.b_addr), 64'h00010);
      ack_after(0, 16'h0);
      chk("wr_ready", 64'({bus.mem_ready, bus.mem_busy, bus.b_req}), 64'b100);
      cyc();
      chk("wr_ready_pulse", 64'(bus.mem_ready), 64'd0);
      repeat (3) cyc();
      chk("wr_no_reserve", 64'(bus.b_req), 64'd0);
      chk("wr_cack_count", 64'(cack_cnt), 64'd2);
      bus.ram_write = 0; bus.data_in = '0;
      repeat (2) cyc();

      // instruction fetch at 0x0003: halves 0x1111 then 0x2222
      mode = 2; exp_instr = 32'h22221111;
      expect_tx(iaddr(3, 0), 1'b0, 16'h0);
      expect_tx(iaddr(3, 1), 1'b0, 16'h0);
      bus.addr_bus = 16'h0003; bus.ram_instr_access = 1; bus.ram_read = 1;
      cyc();
      chk("if_lo_addr", 64'(bus.b_addr), 64'h20006);
      ack_after(1, 16'h1111);
      chk("if_gap", 64'(bus.b_req), 64'd0);
      cyc();
      chk("if_hi_req", 64'(bus.b_req), 64'd1);
      chk("if_hi_addr", 64'(bus.b_addr), 64'h20007);
      ack_after(1, 16'h2222);
      chk("if_ready", 64'({bus.mem_ready, bus.mem_busy}), 64'b10);
      chk("if_word", 64'(bus.sdram_instr), 64'h22221111);
      bus.ram_read_done = 1;
      cyc();
      bus.ram_read_done = 0; bus.ram_read = 0; bus.ram_instr_access = 0;
      repeat (2) cyc();
      chk("if_cack_count", 64'(cack_cnt), 64'd3);

      // simultaneous read and write: only the write happens
      mode = 0;
      expect_tx(daddr(16'h0055), 1'b1, 16'h1357);
      bus.addr_bus = 16'h0055; bus.data_in = 16'h1357; bus.ram_read = 1; bus.ram_write = 1;
      cyc();
      chk("rw_is_write", 64'(bus.b_we), 64'd1);
      ack_after(1, 16'hDEAD);
      chk("rw_ready", 64'(bus.mem_ready), 64'd1);
      chk("rw_no_read", 64'(bus.mem_bus), 64'hBEEF);
      bus.ram_read = 0; bus.ram_write = 0; bus.data_in = '0;
      repeat (3) cyc();
      chk("rw_cack_count", 64'(cack_cnt), 64'd4);

      // reset while the high instruction half is outstanding
      mode = 2; exp_instr = 32'h0;
      expect_tx(iaddr(16'h0100, 0), 1'b0, 16'h0);
      expect_tx(iaddr(16'h0100, 1), 1'b0, 16'h0);
      bus.addr_bus = 16'h0100; bus.ram_instr_access = 1; bus.ram_read = 1;
      cyc();
      ack_after(0, 16'h3333);
      cyc();
      chk("rs_ihi_addr", 64'(bus.b_addr), 64'h20201);
      cyc();
      rst = 1'b1; bus.ram_read = 0; bus.ram_instr_access = 0; bus.addr_bus = '0;
      cyc();
      chk("rs_flags", 64'({bus.mem_busy, bus.mem_ready, bus.ram_cack, bus.b_req, bus.b_we, bus.err}), 64'd0);
      chk("rs_data", 64'({bus.mem_bus, bus.sdram_instr}), 64'd0);
      chk("rs_baddr", 64'(bus.b_addr), 64'd0);
      rst = 1'b0; bus.b_ack = 1; bus.b_rdata = 16'h4444;
      cyc();
      bus.b_ack = 0; bus.b_rdata = '0;
      repeat (3) cyc();
      chk("rs_late_ack", 64'({bus.mem_busy, bus.mem_ready, bus.b_req}), 64'd0);
      chk("rs_late_data", 64'(bus.sdram_instr), 64'd0);
      chk("rs_cack_count", 64'(cack_cnt), 64'd5);

`ifdef MEM_TIMEOUT_EN
      // read with no ack: abort after 4 cycles, fill 0xFFFF, sticky err
      mode = 1; exp_bus = 16'hFFFF;
      expect_tx(daddr(16'h0042), 1'b0, 16'h0);
      bus.addr_bus = 16'h0042; bus.ram_read = 1;
      cyc();
      repeat (3) cyc();
      chk("to_req_held", 64'(bus.b_req), 64'd1);
      cyc();
      chk("to_req_drop", 64'(bus.b_req), 64'd0);
      chk("to_err", 64'(bus.err), 64'd1);
      chk("to_ready", 64'(bus.mem_ready), 64'd1);
      chk("to_fill", 64'(bus.mem_bus), 64'hFFFF);
      bus.ram_read_done = 1;
      cyc();
      bus.ram_read_done = 0; bus.ram_read = 0;
      repeat (2) cyc();
      chk("to_err_sticky", 64'(bus.err), 64'd1);
`else
      chk("err_tied", 64'(bus.err), 64'd0);
`endif

      chk("model_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the core's memory bus: serves data reads, data writes and 32-bit instruction fetches issued by the core.
- Drives busy/ready/cack back to the core, and returns 16-bit read data or 32-bit instruction words.
- Translates each request into one or two word transactions on a simple req/ack backing-store port (SDRAM controller or on-chip RAM).

Parameters:
- BA_W, 18, backing-store word address width (must be ≥18).
- TIMEOUT, 255, cycles without b_ack before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr_bus  in  16  data address, or instruction address when ram_instr_access=1
- data_in  in  16  write data
- ram_read  in  1  read request level (data, or instr if ram_instr_access)
- ram_write  in  1  write request level
- ram_instr_access  in  1  selects instruction space for a read
- ram_read_done  in  1  core has consumed read result
- mem_bus  out  16  data read result
- sdram_instr  out  32  instruction read result
- mem_busy  out  1  transaction in progress
- mem_ready  out  1  result valid / write complete
- ram_cack  out  1  one-cycle pulse: command captured
- b_req  out  1  backing request, held until b_ack
- b_we  out  1  backing write enable
- b_addr  out  BA_W  backing word address
- b_wdata  out  16  backing write data
- b_rdata  in  16  backing read data, valid with b_ack
- b_ack  in  1  one-cycle completion pulse
- err  out  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset: every output 0; FSM to IDLE. Reset mid-transaction drops b_req immediately and abandons the transaction; any late b_ack is ignored.
- States: IDLE, DRD, DWR, ILO, IHI, HOLD, WDONE, RELEASE.
- Requests are sampled only in IDLE. If ram_write and ram_read are both set, the write wins.
- Capture at cycle N:
  - addr, data and mode are latched.
  - At N+1: ram_cack=1 for one cycle, mem_busy=1, b_req=1.
- Address mapping:
  - data: b_addr = {zeros, addr}.
  - instr low half: b_addr = {1'b1, zeros, addr, 1'b0}.
  - instr high half: b_addr = {1'b1, zeros, addr, 1'b1}.
- DRD: on b_ack at cycle M:
  - mem_bus <= b_rdata.
  - At M+1: mem_busy=0, mem_ready=1; go to HOLD.
- DWR: b_we=1, b_wdata = latched data. On b_ack at M:
  - At M+1: mem_busy=0, mem_ready=1 for one cycle (WDONE); then RELEASE.
- ILO: on b_ack, latch sdram_instr[15:0]; the next cycle issue the high-half b_req (IHI).
- IHI: on b_ack, latch sdram_instr[31:16]; the next cycle mem_ready=1, mem_busy=0; go to HOLD.
- HOLD: mem_ready and the result stay stable until ram_read_done=1. Then mem_ready=0 the next cycle; go to RELEASE.
- RELEASE: wait until ram_read=0 and ram_write=0, then IDLE. A held level is never re-served.
- b_req stays asserted and b_addr/b_we stable from issue through the b_ack cycle. b_req deasserts the cycle after b_ack.
- mem_bus and sdram_instr hold their last values outside transactions.
- b_ack while b_req=0 is ignored.
- mem_busy and mem_ready are never both 1.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter resets at each b_req issue.
  - If TIMEOUT cycles pass with no b_ack: drop b_req and set err (sticky until rst).
  - Complete as if acked with data 16'hFFFF: reads return 16'hFFFF, instruction halves 16'hFFFF each, writes report ready.
- MEM_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; err=0.

Decomposition:
- Shared package: FSM state enum, instruction-space select bit position, abort fill value 16'hFFFF.
- One natural sub-module, mem_resp_bport: owns b_req/b_addr/b_we hold-until-ack and the optional timeout counter. It presents start/done/abort to the main FSM.

Test Plan:
- Data read, addr 0x1234, b_ack 3 cycles after b_req with rdata 0xBEEF:
  - b_addr = 0x01234, ram_cack pulses once.
  - mem_ready=1 with mem_bus=0xBEEF held until ram_read_done; then RELEASE until ram_read=0.
- Write, addr 0x0010, data 0xA5A5:
  - b_we=1, b_wdata=0xA5A5, b_addr=0x00010.
  - mem_ready pulses exactly 1 cycle after b_ack; the still-high ram_write is not re-served.
- Instr fetch, addr 0x0003, acks 0x1111 then 0x2222:
  - b_addr 0x20006 then 0x20007; sdram_instr = 0x22221111.
- Simultaneous ram_read=ram_write=1 in IDLE:
  - a write transaction is issued; no read occurs.
- rst asserted while in IHI:
  - next cycle all outputs 0, state IDLE; a following b_ack pulse causes no response.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack on a read:
  - b_req drops after 4 cycles; err=1; mem_ready=1 with mem_bus=0xFFFF.
